// File: rtl/aes_pkg.sv
// Shared AES tables, FSM state type and inverse-round helper functions.
// Byte 0 is bits [127:120]; state is column-major (byte index = 4*col + row).
package aes_pkg;

    typedef enum logic [2:0] {IDLE, KEXP, LOAD, DEC, OUT} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        for (int i = 0; i < 4; i++) begin
            a      = col[31-8*i -: 8];
            x2     = xtime(a);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ a;
            m11[i] = x8 ^ x2 ^ a;
            m13[i] = x8 ^ x4 ^ a;
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0] ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1] ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2] ^ m14[3]};
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_reg,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ak;

    always_comb begin
        sr = inv_shift_rows(state_reg);
        sb = '0;
        for (int i = 0; i < 16; i++)
            sb[127-8*i -: 8] = INV_SBOX[sr[127-8*i -: 8]];
        ak = sb ^ round_key;
        next_state = ak;
        if (!last)
            for (int c = 0; c < 4; c++)
                next_state[127-32*c -: 32] = inv_mix_column(ak[127-32*c -: 32]);
    end

endmodule

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock, on-the-fly keys.
// Define AES_KEY_CACHE_EN to keep round key 10 of the last key for reuse.
module aes_128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_text_128,
    input  logic [127:0] cipher_key_128,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plan_text_128,
    output logic         busy
);

    if (NR != 10) begin : g_nr_chk
        $fatal(1, "aes_128_decrypt_iter: NR must be 10");
    end

    state_t       state, state_nxt;
    logic [127:0] ct_reg, key_reg, state_reg;
    logic [3:0]   rnd, rc_idx;
    logic [127:0] next_rk, prev_rk, dec_nxt;
    logic [31:0]  k0, k1, k2, k3, n0, n1, n2, n3, p0, p1, p2, p3, rc;
    logic         accept, hit, kexp_done;

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    assign accept    = in_valid && in_ready;
    assign kexp_done = (state == KEXP) && (rnd == 4'(NR - 1));

    // Same rcon mux serves the forward step (KEXP) and the inverse step (DEC).
    always_comb begin
        rc_idx = (state == DEC) ? rnd - 4'd1 : rnd;
        rc = {RCON[rc_idx], 24'h0};
        {k0, k1, k2, k3} = key_reg;
        n0 = k0 ^ sub_rot(k3) ^ rc;
        n1 = k1 ^ n0;
        n2 = k2 ^ n1;
        n3 = k3 ^ n2;
        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        p0 = k0 ^ sub_rot(p3) ^ rc;
        next_rk = {n0, n1, n2, n3};
        prev_rk = {p0, p1, p2, p3};
    end

    aes_inv_round u_inv_round (
        .state_reg  (state_reg),
        .round_key  (prev_rk),
        .last       (rnd == 4'd1),
        .next_state (dec_nxt)
    );

`ifdef AES_KEY_CACHE_EN
    logic         cache_vld;
    logic [127:0] cache_key, cache_rk10;

    assign hit = cache_vld && (cipher_key_128 == cache_key);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_vld  <= 1'b0;
            cache_key  <= '0;
            cache_rk10 <= '0;
        end else if (accept && !hit) begin
            cache_vld <= 1'b0;
            cache_key <= cipher_key_128;
        end else if (kexp_done) begin
            cache_vld  <= 1'b1;
            cache_rk10 <= next_rk;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b1;
        plan_text_128 = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = hit ? LOAD : KEXP;
            end
            KEXP: if (kexp_done) state_nxt = DEC;
            LOAD: state_nxt = DEC;
            DEC:  if (rnd == 4'd1) state_nxt = OUT;
            OUT: begin
                out_valid     = 1'b1;
                plan_text_128 = state_reg;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ct_reg    <= '0;
            key_reg   <= '0;
            state_reg <= '0;
            rnd       <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    ct_reg  <= cipher_text_128;
                    key_reg <= cipher_key_128;
                    rnd     <= '0;
                end
                KEXP: begin
                    key_reg <= next_rk;
                    if (kexp_done) begin
                        state_reg <= ct_reg ^ next_rk;
                        rnd       <= 4'(NR);
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
`ifdef AES_KEY_CACHE_EN
                LOAD: begin
                    state_reg <= ct_reg ^ cache_rk10;
                    key_reg   <= cache_rk10;
                    rnd       <= 4'(NR);
                end
`endif
                DEC: begin
                    state_reg <= dec_nxt;
                    key_reg   <= prev_rk;
                    rnd       <= rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_128_decrypt_iter.md
Name: aes_128_decrypt_iter

Overview:
- Iterative AES-128 decryptor: one inverse round per clock, with round keys derived on the fly.
- Receiving-end counterpart of the combinational AES encrypt path; replaces the 10-round unrolled decrypt chain where area matters.
- Sits between the ciphertext source and the plaintext consumer. Uses valid/ready handshakes on both sides.
- Byte order matches the existing AES blocks: bit [127:120] is byte 0, column-major state.

Parameters:
- NR, 10, number of rounds. Only 10 is legal; any other value fires an elaboration-time assertion.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext and key are valid.
- in_ready  output  1  block can accept a new job.
- cipher_text_128  input  128  ciphertext; sampled on the accept edge.
- cipher_key_128  input  128  cipher key; sampled on the accept edge.
- out_valid  output  1  plaintext is valid.
- out_ready  input  1  consumer accepts the plaintext.
- plan_text_128  output  128  decrypted plaintext.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high, all registers):
  - State goes to IDLE; all data registers clear to 0.
  - in_ready=1, out_valid=0, plan_text_128=0, busy=0.
- Accept: happens on a rising edge with in_valid && in_ready. Ciphertext goes to ct_reg, key goes to key_reg, round counter rnd=0.
- State machine:
  - IDLE: in_ready=1. On accept, go to KEXP.
  - KEXP (10 cycles): forward key schedule, key_reg <= next_rk(key_reg, rcon[rnd]), rnd++.
    - On the 10th cycle, state_reg <= ct_reg ^ next_rk, rnd <= 10, then go to DEC.
  - DEC (10 cycles): state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ prev_rk).
    - InvMixColumns is omitted when rnd==1.
    - prev_rk is the inverse key-schedule step of key_reg using rcon[rnd-1]; key_reg <= prev_rk; rnd--.
    - After the rnd==1 cycle, go to OUT.
  - OUT: out_valid=1 and plan_text_128=state_reg, both held stable until out_ready.
    - On out_valid && out_ready, go to IDLE.
- Throughput: one job at a time. in_ready=0 in KEXP, DEC and OUT.
- Latency: 20 clocks from the accept edge to out_valid high; 21 minimum for the full job when out_ready is tied to 1.
- Back-to-back: in_ready rises the cycle after the output handshake. There is no bypass from OUT to accept.
- Input changes while not in IDLE are ignored.
- Reset mid-operation aborts the job with no output produced. The first post-reset accept must decrypt correctly.
- rnd is 4 bits. rcon comes from a 10-entry constant table, indexed 0..9.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- With the macro defined:
  - After each completed KEXP, the block stores the original key and round key 10 in cache registers and sets cache_vld=1. Reset clears cache_vld.
  - On accept, if cache_vld && key==cached key, go to a 1-cycle LOAD state: state_reg <= ct ^ cached_rk10, key_reg <= cached_rk10, rnd <= 10. Then go to DEC.
  - Hit latency is 11 clocks to out_valid; miss latency is 20.
- Without the macro: no cache registers, no LOAD state, latency is always 20.

Decomposition:
- Package aes_pkg holds:
  - SBOX and INV_SBOX 256x8 constant arrays and the RCON[0:9] table.
  - State enum (IDLE, KEXP, LOAD, DEC, OUT).
  - Functions: xtime, inv_mix_column, inv_shift_rows.
- Sub-module aes_inv_round (combinational): inputs state_reg, round key and a last flag; output is the next state. The top level keeps the FSM, the key-schedule logic and the handshakes.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plan_text_128=00112233445566778899aabbccddeeff, with out_valid exactly 20 clocks after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Backpressure: out_ready=0 for 7 cycles -> out_valid and plan_text_128 stay stable, in_ready stays 0; handshake occurs on the first out_ready=1 cycle, and in_ready=1 on the next cycle.
- Reset asserted mid-DEC (rnd=5) -> outputs immediately return to reset values. Then apply the C.1 vector -> correct result after 20 clocks.
- Loopback: random key/plaintext pass through the existing encrypt block, then through this block -> original plaintext; 1000 iterations with random in_valid and out_ready gaps.
- AES_KEY_CACHE_EN:
  - Two C.1 jobs with the same key -> second out_valid 11 clocks after its accept.
  - Changed key -> 20 clocks.
  - Reset between jobs -> 20 clocks.
